// File: rtl/rgb_frame_streamer_if.sv
// rgb_frame_streamer_if: shared channel-memory read port plus the outgoing
// valid/ready pixel stream of rgb_frame_streamer.
// master = the streamer; slave = memories + downstream pixel consumer.
interface rgb_frame_streamer_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 18
) ();
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd;
   logic [DATA_W-1:0] mem_r;
   logic [DATA_W-1:0] mem_g;
   logic [DATA_W-1:0] mem_b;
   logic              px_valid;
   logic              px_ready;
   logic [DATA_W-1:0] px_r;
   logic [DATA_W-1:0] px_g;
   logic [DATA_W-1:0] px_b;
   logic              px_sof;
   logic              px_eol;
   logic              px_eof;

   modport master (
      output mem_addr, mem_rd,
      input  mem_r, mem_g, mem_b,
      output px_valid,
      input  px_ready,
      output px_r, px_g, px_b, px_sof, px_eol, px_eof
   );

   modport slave (
      input  mem_addr, mem_rd,
      output mem_r, mem_g, mem_b,
      input  px_valid,
      output px_ready,
      input  px_r, px_g, px_b, px_sof, px_eol, px_eof
   );
endinterface

// File: rtl/rgb_frame_streamer.sv
// rgb_frame_streamer: reads an RGB image from three channel memories in
// raster order and streams it as one pixel per valid/ready transfer with
// start-of-frame, end-of-line and end-of-frame tags.
// Optional macro RGB_STREAMER_REPEAT_EN: when start is high on the cycle the
// eof pixel is accepted, the next frame begins immediately without passing
// through IDLE.
module rgb_frame_streamer #(
   parameter int DATA_W = 32,
   parameter int IMG_W  = 500,
   parameter int IMG_H  = 500,
   parameter int ADDR_W = 18
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   output logic                 busy,
   rgb_frame_streamer_if.master bus
);
   localparam int COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int LINE_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_W - 1);
   localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(IMG_H - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DRAIN = 2'd2} state_t;

   typedef struct packed {
      logic sof;
      logic eol;
      logic eof;
   } tag_t;

   typedef struct packed {
      logic [DATA_W-1:0] r;
      logic [DATA_W-1:0] g;
      logic [DATA_W-1:0] b;
      tag_t              tag;
   } pix_t;

   state_t            state_r;
   state_t            state_nxt_s;
   logic [ADDR_W-1:0] addr_r;
   logic [COL_W-1:0]  col_r;
   logic [LINE_W-1:0] line_r;
   logic              inflight_r;
   tag_t              inflight_tag_r;
   pix_t              head_r;
   pix_t              tail_r;
   logic [1:0]        count_r;

   logic              pop_s;
   logic              push_s;
   logic              rd_s;
   logic              busy_s;
   logic              last_rd_s;
   logic              eof_pop_s;
   logic [2:0]        credit_s;
   tag_t              issue_tag_s;
   pix_t              push_px_s;

   // A committed entry leaves when the consumer takes it; a read that was
   // in flight last cycle always lands in the buffer this cycle.
   assign pop_s     = (count_r != 2'd0) && bus.px_ready;
   assign push_s    = inflight_r;
   assign eof_pop_s = pop_s && head_r.tag.eof;
   // Outstanding entries after this cycle's pop; a read is allowed only
   // while fewer than two slots are spoken for, so the FIFO cannot overflow.
   assign credit_s  = {1'b0, count_r} + {2'b00, inflight_r} - {2'b00, pop_s};
   assign last_rd_s = rd_s && (col_r == COL_LAST) && (line_r == LINE_LAST);

   assign issue_tag_s.sof = (addr_r == {ADDR_W{1'b0}});
   assign issue_tag_s.eol = (col_r == COL_LAST);
   assign issue_tag_s.eof = (col_r == COL_LAST) && (line_r == LINE_LAST);
   assign push_px_s       = {bus.mem_r, bus.mem_g, bus.mem_b, inflight_tag_r};

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state decision.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) state_nxt_s = FETCH;
            else       state_nxt_s = IDLE;
         end
         FETCH: begin
            if (last_rd_s) state_nxt_s = DRAIN;
            else           state_nxt_s = FETCH;
         end
         DRAIN: begin
            if (eof_pop_s) begin
`ifdef RGB_STREAMER_REPEAT_EN
               if (start) state_nxt_s = FETCH;
               else       state_nxt_s = IDLE;
`else
               state_nxt_s = IDLE;
`endif
            end else begin
               state_nxt_s = DRAIN;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // FSM outputs: read strobe gated by buffer credit, and busy.
   always_comb begin
      rd_s   = 1'b0;
      busy_s = 1'b0;
      case (state_r)
         IDLE: begin
            rd_s   = 1'b0;
            busy_s = 1'b0;
         end
         FETCH: begin
            rd_s   = (credit_s < 3'd2);
            busy_s = 1'b1;
         end
         DRAIN: begin
            rd_s   = 1'b0;
            busy_s = 1'b1;
         end
         default: begin
            rd_s   = 1'b0;
            busy_s = 1'b0;
         end
      endcase
   end

   // Raster address, column and line counters; all wrap to 0 after the
   // last read so a repeated frame starts at pixel 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_r <= {ADDR_W{1'b0}};
         col_r  <= {COL_W{1'b0}};
         line_r <= {LINE_W{1'b0}};
      end else if (rd_s) begin
         if (last_rd_s) begin
            addr_r <= {ADDR_W{1'b0}};
            col_r  <= {COL_W{1'b0}};
            line_r <= {LINE_W{1'b0}};
         end else if (col_r == COL_LAST) begin
            addr_r <= addr_r + ADDR_W'(1);
            col_r  <= {COL_W{1'b0}};
            line_r <= line_r + LINE_W'(1);
         end else begin
            addr_r <= addr_r + ADDR_W'(1);
            col_r  <= col_r + COL_W'(1);
         end
      end else begin
         addr_r <= addr_r;
      end
   end

   // Track the read issued last cycle and the tags of its address.
   always_ff @(posedge clk) begin
      if (rst) begin
         inflight_r     <= 1'b0;
         inflight_tag_r <= '0;
      end else begin
         inflight_r     <= rd_s;
         inflight_tag_r <= issue_tag_s;
      end
   end

   // Two-entry output FIFO kept as head/tail registers so the pixel
   // outputs come straight from flops.
   always_ff @(posedge clk) begin
      if (rst) begin
         head_r  <= '0;
         tail_r  <= '0;
         count_r <= 2'd0;
      end else begin
         case ({push_s, pop_s})
            2'b10: begin
               if (count_r == 2'd0) head_r <= push_px_s;
               else                 tail_r <= push_px_s;
               count_r <= count_r + 2'd1;
            end
            2'b01: begin
               head_r  <= tail_r;
               count_r <= count_r - 2'd1;
            end
            2'b11: begin
               if (count_r == 2'd1) begin
                  head_r <= push_px_s;
               end else begin
                  head_r <= tail_r;
                  tail_r <= push_px_s;
               end
            end
            default: count_r <= count_r;
         endcase
      end
   end

   assign busy         = busy_s;
   assign bus.mem_addr = addr_r;
   assign bus.mem_rd   = rd_s;
   assign bus.px_valid = (count_r != 2'd0);
   assign bus.px_r     = head_r.r;
   assign bus.px_g     = head_r.g;
   assign bus.px_b     = head_r.b;
   assign bus.px_sof   = head_r.tag.sof;
   assign bus.px_eol   = head_r.tag.eol;
   assign bus.px_eof   = head_r.tag.eof;
endmodule

// File: tb/tb_rgb_frame_streamer.sv
// tb_rgb_frame_streamer: randomized self-checking bench for a 4x3 image.
// A negedge monitor collects every accepted pixel; each test task compares
// the collected stream against pixels derived from the image arrays.
`timescale 1ns/1ps
module tb_rgb_frame_streamer;
   localparam int DATA_W = 32;
   localparam int IMG_W  = 4;
   localparam int IMG_H  = 3;
   localparam int ADDR_W = 18;
   localparam int NPIX   = IMG_W * IMG_H;
   localparam int PXW    = 3 * DATA_W + 3;
`ifdef RGB_STREAMER_REPEAT_EN
   localparam int FRAME_GAP = 3;
`else
   localparam int FRAME_GAP = 4;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic busy;

   rgb_frame_streamer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   rgb_frame_streamer #(
      .DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .bus(bus.master)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass   = 0;

   logic [DATA_W-1:0] img_r [NPIX];
   logic [DATA_W-1:0] img_g [NPIX];
   logic [DATA_W-1:0] img_b [NPIX];

   // Synchronous channel memories: one-cycle read latency.
   always @(posedge clk) begin : mem_model
      int a;
      a = int'(bus.mem_addr);
      if (bus.mem_rd === 1'b1) begin
         if (a < NPIX) begin
            bus.mem_r <= img_r[a];
            bus.mem_g <= img_g[a];
            bus.mem_b <= img_b[a];
         end else begin
            bus.mem_r <= '0;
            bus.mem_g <= '0;
            bus.mem_b <= '0;
         end
      end
   end

   // Downstream ready: 0 = always, 1 = 1,0,0,1 pattern, 2 = random 70 %.
   int rdy_mode = 0;
   initial begin : ready_drv
      int ph;
      ph = 0;
      bus.px_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         case (rdy_mode)
            1: begin
               bus.px_ready = (ph == 0 || ph == 3);
               ph = (ph + 1) % 4;
            end
            2: bus.px_ready = ($urandom_range(99) < 70);
            default: bus.px_ready = 1'b1;
         endcase
      end
   end

   // Monitor: accepted pixels, stall stability, outstanding-read bound.
   logic [PXW-1:0] q_px [$];
   int             q_cyc [$];
   int             issued = 0, popped = 0, stable_viol = 0, overrun_viol = 0;
   logic           prev_hold = 1'b0;
   logic [PXW-1:0] prev_px, cur_px;
   always @(negedge clk) begin
      cur_px = {bus.px_r, bus.px_g, bus.px_b, bus.px_sof, bus.px_eol, bus.px_eof};
      if (rst) begin
         issued    = 0;
         popped    = 0;
         prev_hold = 1'b0;
      end else begin
         if (prev_hold && (bus.px_valid !== 1'b1 || cur_px !== prev_px)) stable_viol++;
         if (bus.mem_rd === 1'b1 &&
             (issued - popped - ((bus.px_valid === 1'b1 && bus.px_ready === 1'b1) ? 1 : 0)) >= 2)
            overrun_viol++;
         if (bus.mem_rd === 1'b1) issued++;
         if (bus.px_valid === 1'b1 && bus.px_ready === 1'b1) begin
            q_px.push_back(cur_px);
            q_cyc.push_back(cyc);
            popped++;
         end
         prev_hold = (bus.px_valid === 1'b1 && bus.px_ready !== 1'b1);
         prev_px   = cur_px;
      end
   end

   // Reference pixel p of the frame: data from the image, tags from position.
   function automatic logic [PXW-1:0] exp_px(input int p);
      logic sof, eol, eof;
      sof = (p == 0);
      eol = ((p % IMG_W) == IMG_W - 1);
      eof = (p == NPIX - 1);
      return {img_r[p], img_g[p], img_b[p], sof, eol, eof};
   endfunction

   task automatic load_img(input bit rnd);
      for (int i = 0; i < NPIX; i++) begin
         img_r[i] = rnd ? DATA_W'($urandom) : DATA_W'(i);
         img_g[i] = rnd ? DATA_W'($urandom) : DATA_W'(i + 100);
         img_b[i] = rnd ? DATA_W'($urandom) : DATA_W'(i + 200);
      end
   endtask

   task automatic clear_mon();
      q_px.delete();
      q_cyc.delete();
      stable_viol  = 0;
      overrun_viol = 0;
   endtask

   task automatic pulse_start(output int s_cyc);
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      s_cyc = cyc;
   endtask

   task automatic wait_xfers(input int n, input int budget, output bit ok);
      int k;
      k = 0;
      while (q_px.size() < n && k < budget) begin
         @(posedge clk); #1;
         k++;
      end
      ok = (q_px.size() >= n);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
      n_checks++; if (bus.px_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.px_valid); else n_pass++;
      n_checks++; if (bus.mem_rd !== 1'b0) $display("FAIL reset_rd: got %b want 0", bus.mem_rd); else n_pass++;
      n_checks++; if (bus.mem_addr !== '0) $display("FAIL reset_addr: got %0h want 0", bus.mem_addr); else n_pass++;
      cur_px = {bus.px_r, bus.px_g, bus.px_b, bus.px_sof, bus.px_eol, bus.px_eof};
      n_checks++; if (cur_px !== '0) $display("FAIL reset_px: got %h want 0", cur_px); else n_pass++;
      rst = 1'b0;
   endtask

   task automatic test_stream();
      int s_cyc; bit ok;
      load_img(1'b0);
      rdy_mode = 0;
      clear_mon();
      pulse_start(s_cyc);
      n_checks++; if (busy !== 1'b1) $display("FAIL stream_busy_rise: got %b want 1", busy); else n_pass++;
      wait_xfers(NPIX, 100, ok);
      n_checks++; if (!ok) $display("FAIL stream_timeout: got %0d pixels want %0d", q_px.size(), NPIX); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL stream_busy_fall: got %b want 0", busy); else n_pass++;
      if (ok) begin
         for (int k = 0; k < NPIX; k++) begin
            n_checks++;
            if (q_px[k] !== exp_px(k)) $display("FAIL stream_px[%0d]: got %h want %h", k, q_px[k], exp_px(k));
            else n_pass++;
         end
         n_checks++; if (q_cyc[0] - s_cyc !== 2) $display("FAIL stream_latency: got %0d want 2", q_cyc[0] - s_cyc); else n_pass++;
         n_checks++; if (q_cyc[NPIX-1] - q_cyc[0] !== NPIX - 1) $display("FAIL stream_rate: got %0d want %0d", q_cyc[NPIX-1] - q_cyc[0], NPIX - 1); else n_pass++;
      end
      repeat (6) @(posedge clk);
      #1;
      n_checks++; if (q_px.size() !== NPIX) $display("FAIL stream_extra: got %0d want %0d", q_px.size(), NPIX); else n_pass++;
   endtask

   task automatic test_backpressure();
      int s_cyc; bit ok;
      load_img(1'b1);
      rdy_mode = 1;
      clear_mon();
      pulse_start(s_cyc);
      wait_xfers(NPIX, 200, ok);
      n_checks++; if (!ok) $display("FAIL bp_timeout: got %0d pixels want %0d", q_px.size(), NPIX); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL bp_busy_fall: got %b want 0", busy); else n_pass++;
      if (ok) begin
         for (int k = 0; k < NPIX; k++) begin
            n_checks++;
            if (q_px[k] !== exp_px(k)) $display("FAIL bp_px[%0d]: got %h want %h", k, q_px[k], exp_px(k));
            else n_pass++;
         end
      end
      n_checks++; if (stable_viol !== 0) $display("FAIL bp_stable: got %0d changes want 0", stable_viol); else n_pass++;
      n_checks++; if (overrun_viol !== 0) $display("FAIL bp_credit: got %0d over-reads want 0", overrun_viol); else n_pass++;
      rdy_mode = 0;
   endtask

   task automatic test_start_while_busy();
      int s_cyc; bit ok;
      load_img(1'b1);
      rdy_mode = 0;
      clear_mon();
      pulse_start(s_cyc);
      wait_xfers(5, 100, ok);
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n_checks++; if (busy !== 1'b1) $display("FAIL swb_busy_mid: got %b want 1", busy); else n_pass++;
      wait_xfers(NPIX, 100, ok);
      n_checks++; if (!ok) $display("FAIL swb_timeout: got %0d pixels want %0d", q_px.size(), NPIX); else n_pass++;
      if (ok) begin
         for (int k = 0; k < NPIX; k++) begin
            n_checks++;
            if (q_px[k] !== exp_px(k)) $display("FAIL swb_px[%0d]: got %h want %h", k, q_px[k], exp_px(k));
            else n_pass++;
         end
      end
      repeat (8) @(posedge clk);
      #1;
      n_checks++; if (busy !== 1'b0) $display("FAIL swb_latched: got busy %b want 0", busy); else n_pass++;
      n_checks++; if (q_px.size() !== NPIX) $display("FAIL swb_extra: got %0d want %0d", q_px.size(), NPIX); else n_pass++;
   endtask

   task automatic test_reset_mid();
      int s_cyc; bit ok;
      load_img(1'b1);
      rdy_mode = 1;
      clear_mon();
      pulse_start(s_cyc);
      wait_xfers(6, 100, ok);
      n_checks++; if (!ok) $display("FAIL rstmid_reach: got %0d pixels want 6", q_px.size()); else n_pass++;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n_checks++; if (bus.px_valid !== 1'b0) $display("FAIL rstmid_valid: got %b want 0", bus.px_valid); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy); else n_pass++;
      n_checks++; if (bus.mem_rd !== 1'b0) $display("FAIL rstmid_rd: got %b want 0", bus.mem_rd); else n_pass++;
      rdy_mode = 0;
      clear_mon();
      repeat (6) @(posedge clk);
      #1;
      n_checks++; if (q_px.size() !== 0) $display("FAIL rstmid_ghost: got %0d pixels want 0", q_px.size()); else n_pass++;
      pulse_start(s_cyc);
      wait_xfers(NPIX, 100, ok);
      n_checks++; if (!ok) $display("FAIL rstmid_timeout: got %0d pixels want %0d", q_px.size(), NPIX); else n_pass++;
      if (ok) begin
         for (int k = 0; k < NPIX; k++) begin
            n_checks++;
            if (q_px[k] !== exp_px(k)) $display("FAIL rstmid_px[%0d]: got %h want %h", k, q_px[k], exp_px(k));
            else n_pass++;
         end
      end
   endtask

   task automatic test_start_held();
      bit ok;
      load_img(1'b1);
      rdy_mode = 0;
      clear_mon();
      @(posedge clk); #1;
      start = 1'b1;
      wait_xfers(NPIX + 2, 200, ok);
      start = 1'b0;
      wait_xfers(2 * NPIX, 200, ok);
      n_checks++; if (!ok) $display("FAIL held_timeout: got %0d pixels want %0d", q_px.size(), 2 * NPIX); else n_pass++;
      if (ok) begin
         for (int k = 0; k < 2 * NPIX; k++) begin
            n_checks++;
            if (q_px[k] !== exp_px(k % NPIX)) $display("FAIL held_px[%0d]: got %h want %h", k, q_px[k], exp_px(k % NPIX));
            else n_pass++;
         end
         n_checks++;
         if (q_cyc[NPIX] - q_cyc[NPIX-1] !== FRAME_GAP)
            $display("FAIL held_gap: got %0d want %0d", q_cyc[NPIX] - q_cyc[NPIX-1], FRAME_GAP);
         else n_pass++;
      end
      n_checks++; if (busy !== 1'b0) $display("FAIL held_busy_fall: got %b want 0", busy); else n_pass++;
      repeat (8) @(posedge clk);
      #1;
      n_checks++; if (q_px.size() !== 2 * NPIX) $display("FAIL held_extra: got %0d want %0d", q_px.size(), 2 * NPIX); else n_pass++;
   endtask

   task automatic test_random();
      int s_cyc; bit ok; int n_eol, n_eof, n_sof;
      for (int f = 0; f < 3; f++) begin
         load_img(1'b1);
         rdy_mode = 2;
         clear_mon();
         pulse_start(s_cyc);
         wait_xfers(NPIX, 300, ok);
         n_checks++; if (!ok) $display("FAIL rnd_timeout[%0d]: got %0d pixels want %0d", f, q_px.size(), NPIX); else n_pass++;
         if (ok) begin
            n_eol = 0; n_eof = 0; n_sof = 0;
            for (int k = 0; k < NPIX; k++) begin
               n_checks++;
               if (q_px[k] !== exp_px(k)) $display("FAIL rnd_px[%0d]: got %h want %h", k, q_px[k], exp_px(k));
               else n_pass++;
               n_sof += int'(q_px[k][2]);
               n_eol += int'(q_px[k][1]);
               n_eof += int'(q_px[k][0]);
            end
            n_checks++; if (n_eol !== IMG_H) $display("FAIL rnd_eol_count: got %0d want %0d", n_eol, IMG_H); else n_pass++;
            n_checks++; if (n_eof !== 1) $display("FAIL rnd_eof_count: got %0d want 1", n_eof); else n_pass++;
            n_checks++; if (n_sof !== 1) $display("FAIL rnd_sof_count: got %0d want 1", n_sof); else n_pass++;
         end
         n_checks++; if (stable_viol !== 0) $display("FAIL rnd_stable: got %0d changes want 0", stable_viol); else n_pass++;
         n_checks++; if (overrun_viol !== 0) $display("FAIL rnd_credit: got %0d over-reads want 0", overrun_viol); else n_pass++;
         rdy_mode = 0;
         repeat (4) @(posedge clk);
         #1;
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_start_while_busy();
      test_reset_mid();
      test_start_held();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish want finish before 500000 ns");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/rgb_frame_streamer.md
Name: rgb_frame_streamer

Overview:
- Reads a stored RGB image from three channel memories (red, green, blue) in raster order.
- Emits one pixel per accepted transfer on a valid/ready stream that feeds the pixel-processing datapath (the colour-combining stage that produces one output word per pixel).
- Replaces file/array-driven pixel sourcing with a synthesizable, backpressure-aware source.
- Marks start-of-frame, end-of-line and end-of-frame.

Parameters:
- DATA_W, 32, width of each colour channel word.
- IMG_W, 500, pixels per line.
- IMG_H, 500, lines per frame.
- ADDR_W, 18, memory address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin one frame (sampled in IDLE only)
- busy  out  1  high from frame start until last pixel accepted
- mem_addr  out  ADDR_W  shared read address for all three channel memories
- mem_rd  out  1  read strobe; data returns exactly 1 cycle later
- mem_r  in  DATA_W  red word for the previous cycle's address
- mem_g  in  DATA_W  green word
- mem_b  in  DATA_W  blue word
- px_valid  out  1  pixel present on px_r/g/b
- px_ready  in  1  downstream accepts when px_valid && px_ready
- px_r  out  DATA_W  red
- px_g  out  DATA_W  green
- px_b  out  DATA_W  blue
- px_sof  out  1  pixel (0,0)
- px_eol  out  1  last pixel of a line
- px_eof  out  1  last pixel of the frame

Behaviour:
- Clocking/reset: one clock domain. Reset is synchronous and active-high. Clock and reset ports are named clk and rst.
- Reset values: every output 0; FSM in IDLE; address counter 0; buffer empty; in-flight flag 0.
- FSM states: IDLE, FETCH, DRAIN.
  - IDLE -> FETCH when start=1; busy rises the next cycle.
  - FETCH -> DRAIN after the read for address IMG_W*IMG_H-1 is issued.
  - DRAIN -> IDLE on the cycle the eof pixel is accepted; busy falls the same edge.
- Reads:
  - Address counter runs 0..IMG_W*IMG_H-1 linearly.
  - mem_rd is asserted only in FETCH, and only when (buffer count + in-flight - pop this cycle) < 2.
  - Returned data is written into the 2-entry output buffer in the following cycle, with its tags computed from the address issued.
- Output buffer: 2-entry FIFO; px_* is driven from the head entry.
  - Pop when px_valid && px_ready.
  - Push and pop in the same cycle is allowed.
  - The buffer never overflows: the credit rule guarantees this.
- Throughput: with px_ready held at 1, one pixel per cycle after the initial fill. First px_valid appears 2 cycles after start is sampled.
- Backpressure: px_valid, px_r/g/b and the flags hold stable while px_valid && !px_ready.
- Tags:
  - sof=1 iff address 0.
  - eol=1 iff column == IMG_W-1.
  - eof=1 iff address == IMG_W*IMG_H-1.
  - Column and line counters wrap at IMG_W-1 and IMG_H-1 respectively.
- start: ignored while busy=1. Held high in IDLE, it starts exactly one frame per IDLE visit.
- Reset mid-frame: the sync reset aborts immediately. px_valid=0, and the in-flight read is discarded next cycle.

Optional Feature:
- Macro: RGB_STREAMER_REPEAT_EN.
- Defined:
  - On eof acceptance, if start=1 on that cycle, the FSM goes straight to FETCH with address 0. busy stays high and there is no bubble beyond the memory latency.
  - If start=0, the FSM goes to IDLE.
  - This gives continuous video-like frames while start is held.
- Not defined: always returns to IDLE after eof; a new start is required.

Test Plan:
- IMG_W=4, IMG_H=3, memories hold r=i, g=i+100, b=i+200; start pulse, px_ready=1. Expect 12 pixels on consecutive cycles, px_r = 0..11, sof only on r=0, eol on r=3/7/11, eof only on r=11. busy falls after the eof transfer.
- Same image, px_ready toggling 1,0,0,1 repeating. Expect the output held stable while stalled, no pixel lost or duplicated, sequence still 0..11, and mem_rd never issued when 2 entries are committed.
- start asserted while busy mid-frame (pixel 5). Expect no restart, the frame completes at 11, and start is not latched.
- rst asserted for 1 cycle while pixel 6 is pending. Next cycle: px_valid=0, busy=0, mem_rd=0; a new start replays from pixel 0 with sof.
- RGB_STREAMER_REPEAT_EN defined, start held 1. Expect pixels 0..11, 0..11 back-to-back with a second sof. Drop start during the second frame: it ends at eof and busy goes 0.
- Default 500x500, random px_ready at 70% duty. Expect 250000 transfers, exactly one eof, and 500 eol pulses.
